// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - shared types and constants for the fetch sequencer
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_seq_adder.sv
// rtl/fetch_seq_adder.sv - plain wrap-around adder used for the pc increment
module fetch_seq_adder #(
  parameter int AW = 32
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fetch_seq_skid.sv
// rtl/fetch_seq_skid.sv - single-entry skid buffer holding one fetched word and its pc+4
module fetch_seq_skid
  import fetch_seq_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          drain,
  input  logic          flush,
  input  logic [31:0]   load_instr,
  input  logic [AW-1:0] load_pc4,
  output logic          full,
  output logic [31:0]   instr,
  output logic [AW-1:0] pc4
);

  // flush wins so a redirect never lets a stale word escape
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full  <= 1'b0;
      instr <= INSTR_NOP;
      pc4   <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= load_instr;
      pc4   <= load_pc4;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch FSM with output register, skid buffer and redirect kill
// Optional perf counters enabled by defining FETCH_SEQ_PERF_EN.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          pcsrc,
  input  logic [AW-1:0] pcbranch,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   instr,
  output logic [AW-1:0] pcplus4,
  output logic          instr_valid
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]   perf_wait_cnt,
  output logic [31:0]   perf_flush_cnt
`endif
);

  fetch_state_t  state, state_next;
  logic [AW-1:0] pc, redirect_pc, pc_inc, target;
  logic          kill;
  logic          redirect, consumed, out_free;
  logic          take, drop, skid_load, skid_drain;
  logic          skid_full;
  logic [31:0]   skid_instr;
  logic [AW-1:0] skid_pc4;

  assign redirect  = pcsrc && (state != ST_BOOT);
  assign consumed  = instr_valid && !stall;
  assign out_free  = !instr_valid || !stall;
  assign target    = pcbranch & ~AW'(3);
  assign imem_addr = pc;

  fetch_seq_adder #(.AW(AW)) u_pc_add (
    .a   (pc),
    .b   (AW'(4)),
    .sum (pc_inc)
  );

  fetch_seq_skid #(.AW(AW)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .drain      (skid_drain),
    .flush      (redirect),
    .load_instr (imem_rdata),
    .load_pc4   (pc_inc),
    .full       (skid_full),
    .instr      (skid_instr),
    .pc4        (skid_pc4)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_BOOT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    take       = 1'b0;
    drop       = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    case (state)
      ST_BOOT: state_next = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          state_next = ST_FETCH;
        end else if (imem_ready && kill) begin
          drop = 1'b1;
        end else if (imem_ready && out_free) begin
          take = 1'b1;
        end else if (imem_ready) begin
          skid_load  = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_next = ST_FETCH;
        end else if (out_free && skid_full) begin
          skid_drain = 1'b1;
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_BOOT;
    endcase
  end

  // A redirect with the request still in flight parks the target in redirect_pc
  // so imem_addr stays on the old address until memory completes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      redirect_pc <= RESET_PC;
      kill        <= 1'b0;
      instr       <= INSTR_NOP;
      pcplus4     <= '0;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
      if (state == ST_FETCH && !imem_ready) begin
        kill        <= 1'b1;
        redirect_pc <= target;
      end else begin
        kill <= 1'b0;
        pc   <= target;
      end
    end else if (drop) begin
      kill <= 1'b0;
      pc   <= redirect_pc;
      if (consumed) instr_valid <= 1'b0;
    end else if (take) begin
      instr       <= imem_rdata;
      pcplus4     <= pc_inc;
      instr_valid <= 1'b1;
      pc          <= pc_inc;
    end else if (skid_load) begin
      pc <= pc_inc;
    end else if (skid_drain) begin
      instr       <= skid_instr;
      pcplus4     <= skid_pc4;
      instr_valid <= 1'b1;
    end else if (consumed) begin
      instr_valid <= 1'b0;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_wait_cnt  <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (state == ST_FETCH && !imem_ready && perf_wait_cnt != 32'hFFFF_FFFF)
        perf_wait_cnt <= perf_wait_cnt + 32'd1;
      if (redirect && perf_flush_cnt != 32'hFFFF_FFFF)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer with a variable-latency memory model
module tb_fetch_sequencer;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        pcsrc;
  logic [31:0] pcbranch;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pcplus4;
  logic        instr_valid;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_wait_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int   total = 0;
  int   bad = 0;
  int   cons_cnt = 0;
  int   lat = 1;
  int   wcnt;
  exp_t exp_q[$];

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .pcsrc       (pcsrc),
    .pcbranch    (pcbranch),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pcplus4     (pcplus4),
    .instr_valid (instr_valid)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .perf_wait_cnt  (perf_wait_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_0F0F;
  endfunction

  // memory completes on the lat-th cycle of a request
  always @(posedge clk or negedge reset) begin
    if (!reset) wcnt <= 0;
    else if (imem_req && !imem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign imem_ready = imem_req && (wcnt >= lat - 1);
  assign imem_rdata = mem_word(imem_addr);

  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{instr: mem_word(a), pc4: a + 32'd4});
      a = a + 32'd4;
    end
  endtask

  task automatic sb_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && instr_valid && !stall) begin
        cons_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected instr=%h pcplus4=%h required=no output", instr, pcplus4);
        end else begin
          e = exp_q.pop_front();
          if (instr !== e.instr || pcplus4 !== e.pc4) begin
            bad++;
            $display("FAIL sb_data instr=%h pcplus4=%h required instr=%h pcplus4=%h",
                     instr, pcplus4, e.instr, e.pc4);
          end
        end
      end
    end
  endtask

  task automatic wait_cons(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (cons_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic settle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!imem_req) begin ok = 1'b1; break; end
    end
  endtask

  task automatic redirect(input logic [31:0] tgt);
    @(posedge clk); #1;
    pcsrc = 1'b1; pcbranch = tgt;
    @(posedge clk); #1;
    pcsrc = 1'b0;
  endtask

  task automatic finish_stream(input string name, input int target);
    bit ok;
    wait_cons(target, ok);
    stall = 1'b1;
    total++;
    if (!ok) begin bad++; $display("FAIL %s_timeout consumed=%0d required=%0d", name, cons_cnt, target); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL %s_leftover pending=%0d required=0", name, exp_q.size()); end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl valid=%b req=%b required 0 0", instr_valid, imem_req);
    end
    total++;
    if (instr !== 32'h0 || pcplus4 !== 32'h0) begin
      bad++; $display("FAIL reset_data instr=%h pcplus4=%h required 0 0", instr, pcplus4);
    end
`ifdef FETCH_SEQ_PERF_EN
    total++;
    if (perf_wait_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin
      bad++; $display("FAIL reset_perf wait=%0d flush=%0d required 0 0", perf_wait_cnt, perf_flush_cnt);
    end
`endif
  endtask

  task automatic test_boot();
    logic        req_e [4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic        val_e [4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] addr_e [4] = '{32'h0, 32'h0, 32'h4, 32'h8};
    int base;
    base = cons_cnt;
    push_seq(32'h0, 3);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (imem_req !== req_e[c] || instr_valid !== val_e[c] || (req_e[c] && imem_addr !== addr_e[c])) begin
        bad++;
        $display("FAIL boot_c%0d req=%b valid=%b addr=%h required req=%b valid=%b addr=%h",
                 c + 1, imem_req, instr_valid, imem_addr, req_e[c], val_e[c], addr_e[c]);
      end
    end
    finish_stream("boot", base + 3);
  endtask

  task automatic test_wait();
    bit ok;
    int base;
    logic [31:0] p0;
    settle(ok);
    lat = 3;
    base = cons_cnt;
    push_seq(32'h40, 3);
    redirect(32'h40);
    stall = 1'b0;
    p0 = 32'h0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
`ifdef FETCH_SEQ_PERF_EN
      if (c == 1) p0 = perf_wait_cnt;
`endif
      total++;
      if (c < 4 && (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0)) begin
        bad++; $display("FAIL wait_c%0d req=%b addr=%h valid=%b required 1 00000040 0", c, imem_req, imem_addr, instr_valid);
      end else if (c == 4 && (imem_addr !== 32'h44 || instr_valid !== 1'b1)) begin
        bad++; $display("FAIL wait_c4 addr=%h valid=%b required 00000044 1", imem_addr, instr_valid);
      end
    end
`ifdef FETCH_SEQ_PERF_EN
    total++;
    if (perf_wait_cnt !== p0 + 32'd2) begin
      bad++; $display("FAIL wait_perf count=%0d required=%0d", perf_wait_cnt, p0 + 32'd2);
    end
`endif
    p0 = p0;
    finish_stream("wait", base + 3);
  endtask

  task automatic test_stall_hold();
    bit ok;
    int base;
    settle(ok);
    lat = 1;
    base = cons_cnt;
    push_seq(32'h200, 4);
    redirect(32'h200);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      total++;
      if (c == 1 && (imem_req !== 1'b1 || imem_addr !== 32'h200)) begin
        bad++; $display("FAIL hold_c1 req=%b addr=%h required 1 00000200", imem_req, imem_addr);
      end else if (c == 2 && (imem_addr !== 32'h204 || instr !== mem_word(32'h200))) begin
        bad++; $display("FAIL hold_c2 addr=%h instr=%h required 00000204 %h", imem_addr, instr, mem_word(32'h200));
      end else if (c > 2 && (imem_req !== 1'b0 || instr !== mem_word(32'h200) || instr_valid !== 1'b1)) begin
        bad++; $display("FAIL hold_c%0d req=%b instr=%h valid=%b required 0 %h 1", c, imem_req, instr, instr_valid, mem_word(32'h200));
      end
    end
    @(posedge clk); #1;
    stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (instr !== mem_word(32'h204) || imem_req !== 1'b1 || imem_addr !== 32'h208) begin
      bad++; $display("FAIL hold_release instr=%h req=%b addr=%h required %h 1 00000208", instr, imem_req, imem_addr, mem_word(32'h204));
    end
    finish_stream("hold", base + 4);
  endtask

  task automatic test_kill();
    bit ok;
    int base;
    logic [31:0] addr_e [5] = '{32'h10, 32'h100, 32'h100, 32'h100, 32'h104};
    logic [31:0] f0;
    settle(ok);
    lat = 3;
    base = cons_cnt;
    f0 = 32'h0;
`ifdef FETCH_SEQ_PERF_EN
    f0 = perf_flush_cnt;
`endif
    push_seq(32'h100, 2);
    redirect(32'h10);
    stall = 1'b0;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      bad++; $display("FAIL kill_issue req=%b addr=%h required 1 00000010", imem_req, imem_addr);
    end
    @(posedge clk); #1;
    pcsrc = 1'b1; pcbranch = 32'h0000_0103;
    @(negedge clk);
    total++;
    if (imem_addr !== 32'h10 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL kill_hold addr=%h valid=%b required 00000010 0", imem_addr, instr_valid);
    end
    @(posedge clk); #1;
    pcsrc = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (imem_addr !== addr_e[c] || instr_valid !== (c == 4)) begin
        bad++; $display("FAIL kill_c%0d addr=%h valid=%b required %h %b", c + 3, imem_addr, instr_valid, addr_e[c], c == 4);
      end
`ifdef FETCH_SEQ_PERF_EN
      if (c == 0) begin
        total++;
        if (perf_flush_cnt !== f0 + 32'd2) begin
          bad++; $display("FAIL kill_perf count=%0d required=%0d", perf_flush_cnt, f0 + 32'd2);
        end
      end
`endif
    end
    f0 = f0;
    finish_stream("kill", base + 2);
  endtask

  task automatic test_redirect_ready_stall();
    bit ok;
    int base;
    settle(ok);
    lat = 1;
    redirect(32'h300);
    @(negedge clk);
    total++;
    if (imem_addr !== 32'h300) begin
      bad++; $display("FAIL rrs_issue addr=%h required 00000300", imem_addr);
    end
    @(posedge clk); #1;
    pcsrc = 1'b1; pcbranch = 32'h500;
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b1 || instr !== mem_word(32'h300)) begin
      bad++; $display("FAIL rrs_pre valid=%b instr=%h required 1 %h", instr_valid, instr, mem_word(32'h300));
    end
    @(posedge clk); #1;
    pcsrc = 1'b0;
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h500) begin
      bad++; $display("FAIL rrs_flush valid=%b req=%b addr=%h required 0 1 00000500", instr_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b1 || instr !== mem_word(32'h500)) begin
      bad++; $display("FAIL rrs_target valid=%b instr=%h required 1 %h", instr_valid, instr, mem_word(32'h500));
    end
    base = cons_cnt;
    push_seq(32'h500, 3);
    @(posedge clk); #1;
    stall = 1'b0;
    finish_stream("rrs", base + 3);
  endtask

  task automatic test_wrap();
    bit ok;
    int base;
    settle(ok);
    lat = 1;
    base = cons_cnt;
    push_seq(32'hFFFF_FFF8, 3);
    redirect(32'hFFFF_FFF8);
    stall = 1'b0;
    finish_stream("wrap", base + 3);
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit seen;
    int base;
    settle(ok);
    lat = 1;
    base = cons_cnt;
    push_seq(32'h1000, 8);
    redirect(32'h1000);
    stall = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL b2b_start valid=%b required 1", instr_valid); end
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b1) begin
        bad++; $display("FAIL b2b_gap_%0d valid=%b required 1", k, instr_valid);
      end
    end
    finish_stream("b2b", base + 8);
  endtask

  task automatic test_reset_hold();
    bit ok;
    int base;
    settle(ok);
    total++;
    if (!ok || instr_valid !== 1'b1) begin
      bad++; $display("FAIL rh_hold req=%b valid=%b required 0 1", imem_req, instr_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (instr !== 32'h0 || pcplus4 !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      bad++; $display("FAIL rh_async instr=%h pcplus4=%h valid=%b req=%b required all 0", instr, pcplus4, instr_valid, imem_req);
    end
`ifdef FETCH_SEQ_PERF_EN
    total++;
    if (perf_wait_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin
      bad++; $display("FAIL rh_perf wait=%0d flush=%0d required 0 0", perf_wait_cnt, perf_flush_cnt);
    end
`endif
    base = cons_cnt;
    push_seq(32'h0, 2);
    @(posedge clk); #1;
    reset = 1'b1;
    pcsrc = 1'b1; pcbranch = 32'h700;
    stall = 1'b0;
    @(posedge clk); #1;
    pcsrc = 1'b0;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL rh_restart req=%b addr=%h required 1 00000000", imem_req, imem_addr);
    end
    finish_stream("rh", base + 2);
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    pcsrc = 1'b0;
    pcbranch = 32'h0;
    fork
      sb_monitor();
    join_none
    test_reset();
    test_boot();
    test_wait();
    test_stall_hold();
    test_kill();
    test_redirect_ready_stall();
    test_wrap();
    test_back_to_back();
    test_reset_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t required finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
